obi_error_slave: RTL and testbench

OBI_ERROR_SLAVE -- requirements
Module: obi_error_slave

---
 rtl/obi_pkg.sv | 23 ++
 rtl/obi_error_slave_resp_pipe.sv | 37 +++
 rtl/obi_error_slave.sv | 86 ++++++++
 tb/tb_obi_error_slave.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/obi_pkg.sv
// OBI bus types shared by the crossbar and its slaves, plus the error-slave read-data pattern.
// Combinational definitions only; no latency or backpressure.
// Struct layouts must stay aligned with the crossbar ports.
package obi_pkg;

    typedef struct packed {
        logic        req;
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
    } obi_req_t;

    typedef struct packed {
        logic        gnt;
        logic        rvalid;
        logic [31:0] rdata;
    } obi_resp_t;

    // Returned on every error response so that software can spot unmapped reads.
    localparam logic [31:0] ERR_RDATA_PATTERN = 32'hBADCAB1E;

endpackage

// File: rtl/obi_error_slave_resp_pipe.sv
// rvalid delay line: one bit per accepted request, shifted RESP_LATENCY times.
// Latency RESP_LATENCY cycles; there is no backpressure, one accept per cycle in and one rvalid per cycle out.
// Reset empties the line, so in-flight responses are dropped.
module obi_error_slave_resp_pipe #(
    parameter int unsigned RESP_LATENCY = 1
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic accept,
    output logic rvalid
);

    logic [RESP_LATENCY-1:0] pipe;

    generate
        if (RESP_LATENCY == 1) begin : g_single
            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    pipe <= '0;
                end else begin
                    pipe <= accept;
                end
            end
        end else begin : g_multi
            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    pipe <= '0;
                end else begin
                    pipe <= {pipe[RESP_LATENCY-2:0], accept};
                end
            end
        end
    endgenerate

    assign rvalid = pipe[RESP_LATENCY-1];

endmodule

// File: rtl/obi_error_slave.sv
// Default crossbar slave: grants everything, answers each access with an error pattern and logs the first unmapped access.
// Latency RESP_LATENCY cycles from accept to rvalid; it never backpressures, because gnt follows req.
// Optional macro OBI_ERROR_SLAVE_IRQ_EN adds a registered interrupt that follows the error log.
module obi_error_slave
    import obi_pkg::*;
#(
    parameter int unsigned RESP_LATENCY = 1,
    parameter int unsigned CNT_WIDTH    = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  obi_req_t             slave_req_i,
    output obi_resp_t            slave_resp_o,
    input  logic                 clear_i,
    output logic                 err_valid_o,
    output logic [31:0]          err_addr_o,
    output logic                 err_we_o,
    output logic [CNT_WIDTH-1:0] err_count_o,
    output logic                 irq_o
);

    logic accept;
    logic rvalid;
    logic unused_req_bits;

    // gnt is tied to req, so every raised request is accepted in that cycle.
    assign accept          = slave_req_i.req;
    assign unused_req_bits = ^{slave_req_i.be, slave_req_i.wdata};

    obi_error_slave_resp_pipe #(
        .RESP_LATENCY(RESP_LATENCY)
    ) u_resp_pipe (
        .clk_i (clk_i),
        .rst_ni(rst_ni),
        .accept(accept),
        .rvalid(rvalid)
    );

    assign slave_resp_o = '{
        gnt:    slave_req_i.req,
        rvalid: rvalid,
        rdata:  rvalid ? ERR_RDATA_PATTERN : 32'h0
    };

    // An accept beats a coincident clear: the clear empties the log and the access becomes the new first error.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            err_valid_o <= 1'b0;
            err_addr_o  <= 32'h0;
            err_we_o    <= 1'b0;
            err_count_o <= '0;
        end else if (accept) begin
            if (!err_valid_o || clear_i) begin
                err_addr_o <= slave_req_i.addr;
                err_we_o   <= slave_req_i.we;
            end
            err_valid_o <= 1'b1;
            if (clear_i) begin
                err_count_o <= CNT_WIDTH'(1);
            end else if (err_count_o != '1) begin
                err_count_o <= err_count_o + CNT_WIDTH'(1);
            end
        end else if (clear_i) begin
            err_valid_o <= 1'b0;
            err_addr_o  <= 32'h0;
            err_we_o    <= 1'b0;
            err_count_o <= '0;
        end
    end

`ifdef OBI_ERROR_SLAVE_IRQ_EN
    // Rises one cycle after err_valid_o and drops on the same edge as err_valid_o.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            irq_o <= 1'b0;
        end else if (clear_i && !accept) begin
            irq_o <= 1'b0;
        end else if (err_valid_o) begin
            irq_o <= 1'b1;
        end
    end
`else
    assign irq_o = 1'b0;
`endif

endmodule

// File: tb/tb_obi_error_slave.sv
// Bench for obi_error_slave: directed scenarios on three parameterisations plus a randomized run against a reference model.
module tb_obi_error_slave;
    import obi_pkg::*;

`ifdef OBI_ERROR_SLAVE_IRQ_EN
    localparam bit IRQ_ON = 1'b1;
`else
    localparam bit IRQ_ON = 1'b0;
`endif
    localparam logic [31:0] PAT = 32'hBADCAB1E;

    logic clk;
    logic rst_n;
    int   n_cmp  = 0;
    int   n_fail = 0;

    // d1: latency 1, 16-bit counter
    obi_req_t    q1;
    obi_resp_t   p1;
    logic        c1, v1, w1, i1;
    logic [31:0] a1;
    logic [15:0] n1;
    // d3: latency 3
    obi_req_t    q3;
    obi_resp_t   p3;
    logic        c3, v3, w3, i3;
    logic [31:0] a3;
    logic [15:0] n3;
    // ds: 4-bit counter
    obi_req_t    qs;
    obi_resp_t   ps;
    logic        cs, vs, ws, is_;
    logic [31:0] as_;
    logic [3:0]  ns;

    obi_error_slave #(.RESP_LATENCY(1), .CNT_WIDTH(16)) dut1 (
        .clk_i(clk), .rst_ni(rst_n), .slave_req_i(q1), .slave_resp_o(p1), .clear_i(c1),
        .err_valid_o(v1), .err_addr_o(a1), .err_we_o(w1), .err_count_o(n1), .irq_o(i1));
    obi_error_slave #(.RESP_LATENCY(3), .CNT_WIDTH(16)) dut3 (
        .clk_i(clk), .rst_ni(rst_n), .slave_req_i(q3), .slave_resp_o(p3), .clear_i(c3),
        .err_valid_o(v3), .err_addr_o(a3), .err_we_o(w3), .err_count_o(n3), .irq_o(i3));
    obi_error_slave #(.RESP_LATENCY(1), .CNT_WIDTH(4)) duts (
        .clk_i(clk), .rst_ni(rst_n), .slave_req_i(qs), .slave_resp_o(ps), .clear_i(cs),
        .err_valid_o(vs), .err_addr_o(as_), .err_we_o(ws), .err_count_o(ns), .irq_o(is_));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        q1 = '0; q3 = '0; qs = '0;
        c1 = 1'b0; c3 = 1'b0; cs = 1'b0;
        q1.req = 1'b1;
        #1;
        n_cmp++; if (p1.gnt !== 1'b1) begin n_fail++; $display("FAIL reset_gnt: got %b expected 1", p1.gnt); end
        n_cmp++; if (p1.rvalid !== 1'b0) begin n_fail++; $display("FAIL reset_rvalid: got %b expected 0", p1.rvalid); end
        n_cmp++; if (p1.rdata !== 32'h0) begin n_fail++; $display("FAIL reset_rdata: got %h expected 0", p1.rdata); end
        n_cmp++; if ({v1, w1, i1} !== 3'b000) begin n_fail++; $display("FAIL reset_flags: got %b expected 000", {v1, w1, i1}); end
        n_cmp++; if (a1 !== 32'h0 || n1 !== 16'h0) begin n_fail++; $display("FAIL reset_log: got %h/%h expected 0/0", a1, n1); end
        tick();
        n_cmp++; if (p1.rvalid !== 1'b0 || v1 !== 1'b0) begin n_fail++; $display("FAIL reset_hold: got %b%b expected 00", p1.rvalid, v1); end
        @(negedge clk);
        q1.req = 1'b0;
        rst_n  = 1'b1;
    endtask

    task automatic test_single_read();
        @(negedge clk);
        q1.req = 1'b1; q1.we = 1'b0; q1.addr = 32'hF000_0000;
        #1;
        n_cmp++; if (p1.gnt !== 1'b1) begin n_fail++; $display("FAIL single_gnt: got %b expected 1", p1.gnt); end
        n_cmp++; if (p1.rvalid !== 1'b0) begin n_fail++; $display("FAIL single_early_rvalid: got %b expected 0", p1.rvalid); end
        tick();
        q1.req = 1'b0;
        n_cmp++; if (p1.rvalid !== 1'b1) begin n_fail++; $display("FAIL single_rvalid: got %b expected 1", p1.rvalid); end
        n_cmp++; if (p1.rdata !== PAT) begin n_fail++; $display("FAIL single_rdata: got %h expected %h", p1.rdata, PAT); end
        n_cmp++; if (a1 !== 32'hF000_0000) begin n_fail++; $display("FAIL single_addr: got %h expected f0000000", a1); end
        n_cmp++; if (w1 !== 1'b0 || v1 !== 1'b1) begin n_fail++; $display("FAIL single_we_valid: got %b%b expected 01", w1, v1); end
        n_cmp++; if (n1 !== 16'd1) begin n_fail++; $display("FAIL single_count: got %0d expected 1", n1); end
        n_cmp++; if (i1 !== 1'b0) begin n_fail++; $display("FAIL single_irq_early: got %b expected 0", i1); end
        tick();
        n_cmp++; if (p1.rvalid !== 1'b0 || p1.rdata !== 32'h0) begin n_fail++; $display("FAIL single_rvalid_drop: got %b %h expected 0 0", p1.rvalid, p1.rdata); end
        n_cmp++; if (i1 !== IRQ_ON) begin n_fail++; $display("FAIL single_irq: got %b expected %b", i1, IRQ_ON); end
    endtask

    task automatic test_back_to_back();
        logic rv [8];
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            q3.req  = (i < 4);
            q3.we   = 1'b1;
            q3.addr = 32'hA000_0000 + 32'(i * 4);
            tick();
            rv[i] = p3.rvalid;
        end
        q3.req = 1'b0;
        for (int i = 0; i < 8; i++) begin
            n_cmp++;
            if (rv[i] !== (i >= 2 && i <= 5)) begin
                n_fail++; $display("FAIL b2b_rvalid[%0d]: got %b expected %b", i, rv[i], (i >= 2 && i <= 5));
            end
        end
        n_cmp++; if (w3 !== 1'b1) begin n_fail++; $display("FAIL b2b_we: got %b expected 1", w3); end
        n_cmp++; if (n3 !== 16'd4) begin n_fail++; $display("FAIL b2b_count: got %0d expected 4", n3); end
        n_cmp++; if (a3 !== 32'hA000_0000) begin n_fail++; $display("FAIL b2b_addr: got %h expected a0000000", a3); end
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            qs.req = 1'b1; qs.addr = $urandom; qs.we = 1'($urandom);
            tick();
            n_cmp++;
            if (ns !== 4'((i + 1 > 15) ? 15 : i + 1)) begin
                n_fail++; $display("FAIL sat_count[%0d]: got %0d expected %0d", i, ns, (i + 1 > 15) ? 15 : i + 1);
            end
        end
        @(negedge clk);
        qs.req = 1'b0;
    endtask

    task automatic test_clear();
        @(negedge clk);
        q1.req = 1'b1; q1.we = 1'b1; q1.addr = 32'hE000_0004; c1 = 1'b1;
        tick();
        q1.req = 1'b0; c1 = 1'b0;
        n_cmp++; if (v1 !== 1'b1 || w1 !== 1'b1) begin n_fail++; $display("FAIL clr_acc_flags: got %b%b expected 11", v1, w1); end
        n_cmp++; if (a1 !== 32'hE000_0004) begin n_fail++; $display("FAIL clr_acc_addr: got %h expected e0000004", a1); end
        n_cmp++; if (n1 !== 16'd1) begin n_fail++; $display("FAIL clr_acc_count: got %0d expected 1", n1); end
        n_cmp++; if (i1 !== IRQ_ON) begin n_fail++; $display("FAIL clr_acc_irq: got %b expected %b", i1, IRQ_ON); end
        @(negedge clk);
        c1 = 1'b1;
        tick();
        c1 = 1'b0;
        n_cmp++; if ({v1, w1, i1} !== 3'b000) begin n_fail++; $display("FAIL clr_flags: got %b expected 000", {v1, w1, i1}); end
        n_cmp++; if (a1 !== 32'h0 || n1 !== 16'h0) begin n_fail++; $display("FAIL clr_log: got %h/%0d expected 0/0", a1, n1); end
        // accept on d3, clear alone next cycle: the response must still arrive
        @(negedge clk);
        q3.req = 1'b1; q3.we = 1'b0; q3.addr = 32'hC000_0010;
        tick();
        q3.req = 1'b0;
        @(negedge clk);
        c3 = 1'b1;
        tick();
        c3 = 1'b0;
        n_cmp++; if (v3 !== 1'b0 || n3 !== 16'h0 || a3 !== 32'h0) begin n_fail++; $display("FAIL clr3_log: got %b/%0d/%h expected 0/0/0", v3, n3, a3); end
        n_cmp++; if (p3.rvalid !== 1'b0) begin n_fail++; $display("FAIL clr3_early: got %b expected 0", p3.rvalid); end
        tick();
        n_cmp++; if (p3.rvalid !== 1'b1 || p3.rdata !== PAT) begin n_fail++; $display("FAIL clr3_pending: got %b %h expected 1 %h", p3.rvalid, p3.rdata, PAT); end
        tick();
    endtask

    task automatic test_reset_in_flight();
        int seen = 0;
        @(negedge clk);
        q3.req = 1'b1; q3.we = 1'b1; q3.addr = 32'hD000_0000;
        tick();
        tick();
        q3.req = 1'b0;
        rst_n  = 1'b0;
        #1;
        n_cmp++; if ({p3.rvalid, v3, w3, i3} !== 4'b0000) begin n_fail++; $display("FAIL rst_flight_flags: got %b expected 0000", {p3.rvalid, v3, w3, i3}); end
        n_cmp++; if (a3 !== 32'h0 || n3 !== 16'h0) begin n_fail++; $display("FAIL rst_flight_log: got %h/%0d expected 0/0", a3, n3); end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (p3.rvalid !== 1'b0) seen++;
        end
        n_cmp++; if (seen != 0) begin n_fail++; $display("FAIL rst_flight_rvalid: got %0d rvalids expected 0", seen); end
        n_cmp++; if (v3 !== 1'b0 || n3 !== 16'h0) begin n_fail++; $display("FAIL rst_flight_after: got %b/%0d expected 0/0", v3, n3); end
    endtask

    task automatic test_random();
        bit          acc_q[$];
        bit          m_valid = 1'b0, m_prev = 1'b0, m_we = 1'b0;
        logic [31:0] m_addr = 32'h0;
        int          m_cnt = 0;
        bit          exp_rv;
        @(negedge clk);
        rst_n = 1'b0; q1 = '0; c1 = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int cyc = 0; cyc < 400; cyc++) begin
            @(negedge clk);
            q1.req   = ($urandom_range(0, 99) < 60);
            q1.we    = 1'($urandom);
            q1.addr  = $urandom;
            q1.wdata = $urandom;
            q1.be    = 4'($urandom);
            c1       = ($urandom_range(0, 99) < 8);
            #1;
            n_cmp++; if (p1.gnt !== q1.req) begin n_fail++; $display("FAIL rnd_gnt@%0d: got %b expected %b", cyc, p1.gnt, q1.req); end
            @(posedge clk);
            m_prev = m_valid;
            acc_q.push_back(q1.req);
            if (q1.req) begin
                if (!m_valid || c1) begin m_addr = q1.addr; m_we = q1.we; end
                m_valid = 1'b1;
                m_cnt   = c1 ? 1 : ((m_cnt + 1 > 65535) ? 65535 : m_cnt + 1);
            end else if (c1) begin
                m_valid = 1'b0; m_addr = 32'h0; m_we = 1'b0; m_cnt = 0;
            end
            exp_rv = acc_q[acc_q.size() - 1];
            #1;
            n_cmp++; if (p1.rvalid !== exp_rv) begin n_fail++; $display("FAIL rnd_rvalid@%0d: got %b expected %b", cyc, p1.rvalid, exp_rv); end
            n_cmp++; if (p1.rdata !== (exp_rv ? PAT : 32'h0)) begin n_fail++; $display("FAIL rnd_rdata@%0d: got %h", cyc, p1.rdata); end
            n_cmp++; if (v1 !== m_valid || w1 !== m_we) begin n_fail++; $display("FAIL rnd_flags@%0d: got %b%b expected %b%b", cyc, v1, w1, m_valid, m_we); end
            n_cmp++; if (a1 !== m_addr) begin n_fail++; $display("FAIL rnd_addr@%0d: got %h expected %h", cyc, a1, m_addr); end
            n_cmp++; if (n1 !== 16'(m_cnt)) begin n_fail++; $display("FAIL rnd_count@%0d: got %0d expected %0d", cyc, n1, m_cnt); end
            n_cmp++; if (i1 !== (IRQ_ON & m_valid & m_prev)) begin n_fail++; $display("FAIL rnd_irq@%0d: got %b expected %b", cyc, i1, IRQ_ON & m_valid & m_prev); end
        end
        @(negedge clk);
        q1.req = 1'b0; c1 = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_back_to_back();
        test_saturation();
        test_clear();
        test_reset_in_flight();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
